// File: rtl/alu_seq.sv
// Multi-cycle ALU with valid/ready on both sides. Single-cycle ops finish on the
// accepting edge; mul (shift-add) and divu (restoring) iterate WIDTH times.
module alu_seq #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       cmd,
  input  logic [15:0]      flag,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic [15:0]      rflag
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both 1;
  // producers keep data stable while valid is high and not yet accepted.
  localparam int M = WIDTH - 1;
  localparam logic [5:0] OP_MOV  = 6'b010000;
  localparam logic [5:0] OP_NOT  = 6'b010001;
  localparam logic [5:0] OP_AND  = 6'b010010;
  localparam logic [5:0] OP_OR   = 6'b010011;
  localparam logic [5:0] OP_XOR  = 6'b010100;
  localparam logic [5:0] OP_SHL  = 6'b010101;
  localparam logic [5:0] OP_SHR  = 6'b010111;
  localparam logic [5:0] OP_SAR  = 6'b011001;
  localparam logic [5:0] OP_ADD  = 6'b011010;
  localparam logic [5:0] OP_ADC  = 6'b011011;
  localparam logic [5:0] OP_SUB  = 6'b011100;
  localparam logic [5:0] OP_SBB  = 6'b011101;
  localparam logic [5:0] OP_NEG  = 6'b011110;
  localparam logic [5:0] OP_MUL  = 6'b100000;
  localparam logic [5:0] OP_DIVU = 6'b100001;
  localparam logic [WIDTH-1:0] W_VAL = WIDTH'(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               is_mul_q, is_mul_d;
  logic [WIDTH-1:0]   acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0]   acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [WIDTH-1:0]   result_hi_q, result_hi_d;
  logic [15:0]        rflag_q, rflag_d;

  logic unused_flag;
  assign unused_flag = ^{flag[15:14], flag[12:0]};

  // Single-cycle datapath straight from the input operands.
  logic [WIDTH:0]          sc_sum;
  logic [WIDTH-1:0]        sc_r, sc_hi;
  logic signed [WIDTH-1:0] sar_s;
  logic                    sc_c, sc_o, sc_def, sc_iter, big_shift, c_in;
  logic [15:0]             sc_flag;

  always_comb begin
    sc_sum    = '0;
    sc_r      = op2;
    sc_hi     = '0;
    sc_c      = 1'b0;
    sc_o      = 1'b0;
    sc_def    = 1'b1;
    sc_iter   = 1'b0;
    c_in      = flag[13];
    big_shift = (op1 >= W_VAL);
    sar_s     = $signed(op2) >>> op1;
    case (cmd)
      OP_MOV: sc_r = op1;
      OP_NOT: sc_r = ~op1;
      OP_AND: sc_r = op1 & op2;
      OP_OR:  sc_r = op1 | op2;
      OP_XOR: sc_r = op1 ^ op2;
      OP_SHL: sc_r = big_shift ? '0 : (op2 << op1);
      OP_SHR: sc_r = big_shift ? '0 : (op2 >> op1);
      OP_SAR: sc_r = big_shift ? {WIDTH{op2[M]}} : sar_s;
      OP_ADD, OP_ADC: begin
        sc_sum = {1'b0, op2} + {1'b0, op1} + {{WIDTH{1'b0}}, (cmd == OP_ADC) & c_in};
        sc_r   = sc_sum[M:0];
        sc_c   = sc_sum[WIDTH];
        sc_o   = (op2[M] == op1[M]) && (sc_sum[M] != op2[M]);
      end
      OP_SUB, OP_SBB: begin
        sc_sum = {1'b0, op2} - {1'b0, op1} - {{WIDTH{1'b0}}, (cmd == OP_SBB) & c_in};
        sc_r   = sc_sum[M:0];
        sc_c   = sc_sum[WIDTH];
        sc_o   = (op2[M] != op1[M]) && (sc_sum[M] != op2[M]);
      end
      OP_NEG: begin
        sc_sum = {(WIDTH+1){1'b0}} - {1'b0, op1};
        sc_r   = sc_sum[M:0];
        sc_c   = (op1 != '0);
        sc_o   = op1[M] && sc_sum[M];
      end
      OP_MUL: sc_iter = 1'b1;
      OP_DIVU: begin
        if (op1 == '0) begin
          sc_r  = '1;
          sc_hi = op2;
          sc_c  = 1'b1;
        end else begin
          sc_iter = 1'b1;
        end
      end
      default: sc_def = 1'b0;
    endcase
    sc_flag = sc_def ? {sc_r[M], sc_r == '0, sc_c, sc_o, 1'b0, ^sc_r, 10'b0} : 16'h0000;
  end

  // One iteration: mul keeps {hi,lo} as partial product / multiplier, divu keeps
  // remainder / dividend-shifting-into-quotient.
  logic [WIDTH:0]   mul_sum, rem_sh, trial;
  logic [WIDTH-1:0] step_hi, step_lo;
  logic [15:0]      it_flag;

  always_comb begin
    mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
    rem_sh  = {acc_hi_q, acc_lo_q[M]};
    trial   = rem_sh - {1'b0, opnd_q};
    if (is_mul_q) begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], acc_lo_q[M:1]};
    end else if (!trial[WIDTH]) begin
      step_hi = trial[M:0];
      step_lo = {acc_lo_q[M-1:0], 1'b1};
    end else begin
      step_hi = rem_sh[M:0];
      step_lo = {acc_lo_q[M-1:0], 1'b0};
    end
    if (is_mul_q) begin
      it_flag = {step_lo[M], (step_hi == '0) && (step_lo == '0), step_hi != '0,
                 step_hi != '0, 1'b0, ^step_lo, 10'b0};
    end else begin
      it_flag = {step_lo[M], step_lo == '0, 1'b0, 1'b0, 1'b0, ^step_lo, 10'b0};
    end
  end

  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign result_hi = result_hi_q;
  assign rflag     = rflag_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    is_mul_d    = is_mul_q;
    acc_hi_d    = acc_hi_q;
    acc_lo_d    = acc_lo_q;
    opnd_d      = opnd_q;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    rflag_d     = rflag_q;
    case (state_q)
      IDLE, DONE: begin
        if (state_q == DONE && out_ready) state_d = IDLE;
        if (in_valid && in_ready) begin
          if (sc_iter) begin
            state_d  = CALC;
            cnt_d    = CNT_W'(WIDTH);
            is_mul_d = (cmd == OP_MUL);
            acc_hi_d = '0;
            acc_lo_d = op2;
            opnd_d   = op1;
          end else begin
            state_d     = DONE;
            result_d    = sc_r;
            result_hi_d = sc_hi;
            rflag_d     = sc_flag;
          end
        end
      end
      CALC: begin
        acc_hi_d = step_hi;
        acc_lo_d = step_lo;
        cnt_d    = cnt_q - CNT_W'(1);
        // The last iteration's output goes straight to the result registers.
        if (cnt_q == CNT_W'(1)) begin
          state_d     = DONE;
          result_d    = step_lo;
          result_hi_d = step_hi;
          rflag_d     = it_flag;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      is_mul_q    <= 1'b0;
      acc_hi_q    <= '0;
      acc_lo_q    <= '0;
      opnd_q      <= '0;
      result_q    <= '0;
      result_hi_q <= '0;
      rflag_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      is_mul_q    <= is_mul_d;
      acc_hi_q    <= acc_hi_d;
      acc_lo_q    <= acc_lo_d;
      opnd_q      <= opnd_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      rflag_q     <= rflag_d;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed literal cases, backpressure, reset abort, then
// randomized traffic checked every cycle against an arithmetic reference model.
module tb_alu_seq;

  logic        clk, rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [5:0]  cmd;
  logic [15:0] flag, op1, op2, result, result_hi, rflag;

  alu_seq #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .cmd(cmd), .flag(flag), .op1(op1), .op2(op2), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .result_hi(result_hi), .rflag(rflag)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [15:0] r;
    logic [15:0] hi;
    logic [15:0] f;
    logic [7:0]  lat;
    logic [31:0] acc;
  } exp_t;

  // Reference model: plain integer arithmetic on the operation's meaning.
  function automatic exp_t model(input logic [5:0] c, input logic [15:0] a,
                                 input logic [15:0] b, input logic cin);
    exp_t   e;
    int     full, sv, sh;
    longint p;
    logic   cf, o, def, z;
    e = '0; e.lat = 8'd1; e.r = b;
    cf = 1'b0; o = 1'b0; def = 1'b1; p = 0;
    sh = (a >= 16) ? 16 : int'(a);
    case (c)
      6'b010000: e.r = a;
      6'b010001: e.r = ~a;
      6'b010010: e.r = a & b;
      6'b010011: e.r = a | b;
      6'b010100: e.r = a ^ b;
      6'b010101: e.r = (sh >= 16) ? 16'h0 : 16'(b << sh);
      6'b010111: e.r = (sh >= 16) ? 16'h0 : 16'(b >> sh);
      6'b011001: begin
        sv = int'($signed(b));
        e.r = 16'(sv >>> ((sh >= 16) ? 15 : sh));
      end
      6'b011010, 6'b011011: begin
        full = int'(b) + int'(a) + ((c == 6'b011011) ? int'(cin) : 0);
        sv = int'($signed(b)) + int'($signed(a)) + ((c == 6'b011011) ? int'(cin) : 0);
        e.r = 16'(full); cf = full > 65535; o = (sv > 32767) || (sv < -32768);
      end
      6'b011100, 6'b011101: begin
        full = int'(b) - int'(a) - ((c == 6'b011101) ? int'(cin) : 0);
        sv = int'($signed(b)) - int'($signed(a)) - ((c == 6'b011101) ? int'(cin) : 0);
        e.r = 16'(full); cf = full < 0; o = (sv > 32767) || (sv < -32768);
      end
      6'b011110: begin
        sv = -int'($signed(a));
        e.r = 16'(sv); cf = (a != 0); o = (sv > 32767);
      end
      6'b100000: begin
        p = longint'(a) * longint'(b);
        e.r = 16'(p); e.hi = 16'(p >> 16); cf = (e.hi != 0); o = cf; e.lat = 8'd17;
      end
      6'b100001: begin
        if (a == 0) begin
          e.r = 16'hFFFF; e.hi = b; cf = 1'b1;
        end else begin
          e.r = b / a; e.hi = b % a; e.lat = 8'd17;
        end
      end
      default: def = 1'b0;
    endcase
    z = (c == 6'b100000) ? (p == 0) : (e.r == 0);
    e.f = def ? {e.r[15], z, cf, o, 1'b0, ^e.r, 10'b0} : 16'h0;
    return e;
  endfunction

  // scoreboard: one compare process, checks every cycle a result is presented
  exp_t exp_q[$];
  bit   head_seen = 0;
  int   wait_cnt = 0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      exp_q.delete();
      head_seen = 0;
      wait_cnt = 0;
    end else begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out_valid", {31'b0, out_valid}, 32'd0);
        end else begin
          e = exp_q[0];
          wait_cnt = 0;
          if (!head_seen) begin
            chk("latency", cyc - e.acc, {24'b0, e.lat});
            head_seen = 1;
          end
          chk("result", {16'b0, result}, {16'b0, e.r});
          chk("result_hi", {16'b0, result_hi}, {16'b0, e.hi});
          chk("rflag", {16'b0, rflag}, {16'b0, e.f});
          if (out_ready) begin
            void'(exp_q.pop_front());
            head_seen = 0;
          end
        end
      end else if (exp_q.size() > 0) begin
        wait_cnt++;
        if (wait_cnt > 60) begin
          chk("out_valid_timeout", {31'b0, out_valid}, 32'd1);
          void'(exp_q.pop_front());
          wait_cnt = 0;
          head_seen = 0;
        end
      end
      if (in_valid && in_ready) begin
        e = model(cmd, op1, op2, flag[13]);
        e.acc = cyc;
        exp_q.push_back(e);
      end
    end
  end

  // driver tasks
  task automatic run_op(input string name, input logic [5:0] c, input logic [15:0] a,
                        input logic [15:0] b, input logic cin, input logic [15:0] er,
                        input logic [15:0] ehi, input logic [15:0] ef, input int elat);
    int lat;
    cmd = c; op1 = a; op2 = b; flag = {2'b00, cin, 13'h0}; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({name, "_lat"}, lat, elat);
    chk({name, "_r"}, {16'b0, result}, {16'b0, er});
    chk({name, "_hi"}, {16'b0, result_hi}, {16'b0, ehi});
    chk({name, "_flag"}, {16'b0, rflag}, {16'b0, ef});
  endtask

  function automatic logic [15:0] rnd_val();
    case ($urandom_range(0, 5))
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'h8000;
      3: return 16'h7FFF;
      4: return 16'($urandom_range(0, 20));
      default: return 16'($urandom_range(0, 65535));
    endcase
  endfunction

  logic [5:0]  ops [16] = '{6'b010000, 6'b010001, 6'b010010, 6'b010011, 6'b010100,
                             6'b010101, 6'b010111, 6'b011001, 6'b011010, 6'b011011,
                             6'b011100, 6'b011101, 6'b011110, 6'b100000, 6'b100001,
                             6'b111111};
  logic [15:0] mov_vals [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};

  initial begin
    bit took;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    cmd = '0; op1 = '0; op2 = '0; flag = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_result", {16'b0, result}, 32'd0);
    chk("rst_result_hi", {16'b0, result_hi}, 32'd0);
    chk("rst_rflag", {16'b0, rflag}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);

    // reset in the middle of a mul
    cmd = 6'b100000; op1 = 16'hFFFF; op2 = 16'hFFFF; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_out_valid", {31'b0, out_valid}, 32'd0);
    chk("abort_result", {16'b0, result}, 32'd0);
    chk("abort_result_hi", {16'b0, result_hi}, 32'd0);
    chk("abort_rflag", {16'b0, rflag}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1 chk("abort_no_result", {31'b0, out_valid}, 32'd0);

    // directed literal cases
    run_op("add_1_2",   6'b011010, 16'h0001, 16'h0002, 1'b0, 16'h0003, 16'h0, 16'h0000, 1);
    run_op("add_ovf",   6'b011010, 16'h0001, 16'h7FFF, 1'b0, 16'h8000, 16'h0, 16'h9400, 1);
    run_op("adc_wrap",  6'b011011, 16'h0000, 16'hFFFF, 1'b1, 16'h0000, 16'h0, 16'h6000, 1);
    run_op("sub_5_7",   6'b011100, 16'h0007, 16'h0005, 1'b0, 16'hFFFE, 16'h0, 16'hA400, 1);
    run_op("sar_20",    6'b011001, 16'd20,   16'h8000, 1'b0, 16'hFFFF, 16'h0, 16'h8000, 1);
    run_op("shl_16",    6'b010101, 16'd16,   16'h1234, 1'b0, 16'h0000, 16'h0, 16'h4000, 1);
    run_op("mul_max",   6'b100000, 16'hFFFF, 16'hFFFF, 1'b0, 16'h0001, 16'hFFFE, 16'h3400, 17);
    run_op("divu_100",  6'b100001, 16'd7,    16'd100,  1'b0, 16'd14,   16'd2,   16'h0400, 17);
    run_op("divu_zero", 6'b100001, 16'd0,    16'd9,    1'b0, 16'hFFFF, 16'd9,   16'hA000, 1);
    run_op("undef",     6'b000111, 16'h1234, 16'h5678, 1'b1, 16'h5678, 16'h0,   16'h0000, 1);

    // backpressure: hold an xor result, then stream movs
    @(posedge clk); #1;
    cmd = 6'b010100; op1 = 16'hF0F0; op2 = 16'hFF00; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    cmd = 6'b010000; op1 = mov_vals[0];
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", {31'b0, out_valid}, 32'd1);
      chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
      chk("bp_result", {16'b0, result}, 32'h0FF0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      op1 = mov_vals[i];
      @(posedge clk); #1;
      chk("stream_valid", {31'b0, out_valid}, 32'd1);
      chk("stream_result", {16'b0, result}, {16'b0, mov_vals[i]});
    end
    in_valid = 1'b0;
    @(posedge clk); #1;

    // randomized traffic with random backpressure
    took = 1'b1;
    repeat (1500) begin
      if (took || !in_valid) begin
        if ($urandom_range(0, 3) != 0) begin
          in_valid = 1'b1;
          cmd = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(0, 63))
                                            : ops[$urandom_range(0, 15)];
          op1 = rnd_val();
          op2 = rnd_val();
          flag = 16'($urandom_range(0, 65535));
        end else begin
          in_valid = 1'b0;
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
      #1 took = in_valid && in_ready;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (40) @(posedge clk);
    #1 chk("drain_queue_empty", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, multi-cycle successor to the processor's combinational ALU.
- Adds a valid/ready handshake on both input and output.
- Adds iterative unsigned multiply (2·WIDTH-bit product) and unsigned divide with remainder.
- Sits between operand fetch and writeback. The 16-bit flag word layout is unchanged so existing flag consumers keep working.

Parameters:
- WIDTH, 16, operand/result width in bits; minimum 4.
- CNT_W, $clog2(WIDTH+1), width of the iteration counter.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  command/operands valid.
- in_ready  output  1  block can accept a command.
- cmd  input  6  operation code.
- flag  input  16  incoming flag word; only C (bit 13) is used, by adc/sbb.
- op1  input  WIDTH  operand 1 (subtrahend, shift amount, divisor).
- op2  input  WIDTH  operand 2 (minuend, shifted value, dividend).
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- result  output  WIDTH  primary result.
- result_hi  output  WIDTH  product high half or remainder; 0 for other ops.
- rflag  output  16  result flags: S=15, Z=14, C=13, O=12, P=10; bits 11 and 9:0 always 0.

Behaviour:
- Reset (async, rst_n=0): state=IDLE. out_valid=0, result=0, result_hi=0, rflag=0, counter=0. in_ready=1 once out of reset.
- States: IDLE, CALC, DONE.
- Acceptance: a command is accepted on a cycle where in_valid && in_ready. cmd/op1/op2/flag[13] are latched on that edge.
- in_ready = (state==IDLE) || (state==DONE && out_ready).
- Back-to-back single-cycle ops give one result per cycle.
- Single-cycle ops: accept → DONE on the next edge; latency 1.
- Iterative ops: accept → CALC. The counter loads WIDTH and decrements each cycle. At count 0 → DONE; latency WIDTH+1.
- DONE: out_valid=1. result, result_hi and rflag are held stable until out_ready=1.
  - out_ready && no new accept → IDLE, out_valid=0.
  - out_ready && new accept → DONE or CALC per the new op.
- in_valid is ignored while in CALC, or in DONE without out_ready.
- Opcodes:
  - 010000 mov: result = op1.
  - 010001 not: result = ~op1.
  - 010010 and: result = op1 & op2.
  - 010011 or: result = op1 | op2 (bitwise).
  - 010100 xor: result = op1 ^ op2.
  - 010101 shl: result = op2 << op1.
  - 010111 shr: result = op2 >> op1 (logical).
  - 011001 sar: result = op2 >>> op1 (arithmetic).
  - 011010 add: result = op2 + op1.
  - 011011 adc: result = op2 + op1 + C.
  - 011100 sub: result = op2 − op1.
  - 011101 sbb: result = op2 − op1 − C.
  - 011110 neg: result = −op1.
  - 100000 mul: unsigned op1×op2, shift-add, iterative.
  - 100001 divu: op2÷op1 unsigned, restoring, iterative.
  - Any other code: result = op2, result_hi = 0, rflag = 0, latency 1.
- Shift amounts ≥ WIDTH: shl and shr give 0; sar gives all copies of op2[WIDTH-1].
- Arithmetic is done at WIDTH+1 bits.
  - C = carry out (add/adc) or borrow (sub/sbb/neg with op1≠0).
  - O = signed overflow, computed from the operand and result MSBs. For sub/sbb/neg the effective operand is the negated subtrahend.
- mul: {result_hi, result} = full 2·WIDTH product. C = O = (result_hi≠0).
- divu: result = quotient, result_hi = remainder, C = O = 0.
- divu with op1==0: no iteration; latency 1. result = all ones, result_hi = op2, C=1, O=0.
- Flags for every defined opcode:
  - S = result[WIDTH-1].
  - Z = (result==0); for mul, Z = whole product is 0.
  - P = XOR-reduce(result).
- C and O are 0 for logical ops and shifts. Undefined opcodes give all flags 0.
- Async reset mid-CALC or mid-DONE aborts the operation. The pending result is discarded and not presented after reset.

Test Plan:
- Reset while in CALC of mul (cycle 5) → out_valid=0, all outputs 0 immediately. A new add 1+2 completes with result=3.
- add op2=16'h7FFF, op1=16'h0001 → result=16'h8000, S=1, Z=0, C=0, O=1, P=1, latency 1. adc with flag[13]=1, op2=16'hFFFF, op1=0 → result=0, Z=1, C=1.
- sub op2=5, op1=7 → result=16'hFFFE, C=1, O=0. sar op2=16'h8000, op1=20 → result=16'hFFFF. shl op1=16 → result=0.
- mul op1=16'hFFFF, op2=16'hFFFF → result=16'h0001, result_hi=16'hFFFE, C=O=1. out_valid rises exactly 17 cycles after accept.
- divu op2=100, op1=7 → result=14, result_hi=2, latency 17. divu op1=0, op2=9 → result=16'hFFFF, result_hi=9, C=1, latency 1.
- Backpressure: hold out_ready=0 for 5 cycles after an xor completes → outputs stable, in_ready=0. Then a stream of 4 movs with out_ready=1 → one result per cycle, in order.
